// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit.
// Holds the ramOp encodings carried in EX/MEM, the FSM state type, and
// op-classification helpers used by the unit and its lane formatter.
package mem_access_unit_pkg;

  localparam logic [3:0] MEM_NOP = 4'h0;
  localparam logic [3:0] MEM_LB  = 4'h1;
  localparam logic [3:0] MEM_LBU = 4'h2;
  localparam logic [3:0] MEM_LH  = 4'h3;
  localparam logic [3:0] MEM_LHU = 4'h4;
  localparam logic [3:0] MEM_LW  = 4'h5;
  localparam logic [3:0] MEM_SB  = 4'h6;
  localparam logic [3:0] MEM_SH  = 4'h7;
  localparam logic [3:0] MEM_SW  = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_DRAIN
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfword ops need addr[0]==0, word ops need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    if ((op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH)) r = lo[0];
    else if ((op == MEM_LW) || (op == MEM_SW))               r = |lo;
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_format.sv
// Combinational byte-lane formatter (little-endian).
// Store side: byte enables and lane-replicated write data for the op being issued.
// Load side : lane extraction and sign/zero extension of returned read data.
// Ports:
//   i_st_op, i_st_addr_lo, i_st_data -> o_be, o_wdata
//   i_ld_op, i_ld_addr_lo, i_rdata   -> o_load_data
module mem_lane_format
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  i_st_op,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [3:0]  i_ld_op,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_data;
    case (i_st_op)
      MEM_SB: begin
        o_be    = 4'b0001 << i_st_addr_lo;
        o_wdata = {4{i_st_data[7:0]}};
      end
      MEM_SH: begin
        o_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_ld_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_load_data = i_rdata;
    case (i_ld_op)
      MEM_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_load_data = {24'h0, w_byte};
      MEM_LH:  o_load_data = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_load_data = {16'h0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit.
// Converts the EX/MEM ramOp into a single req/ack bus transaction, formats
// load data, stalls the pipeline while a transaction is outstanding, and
// flags misaligned loads/stores (AdEL/AdES) without touching the bus.
// Ports:
//   clk, rst (sync, active high)
//   ramOp_i, addr_i, storeData_i, flush     : pipeline side inputs
//   bus_req_o/we/be/addr/wdata, bus_ack_i, bus_rdata_i : memory bus
//   load_data_o, load_valid_o               : formatted load result
//   stall_req_o                             : hold request to stall control
//   adel_o, ades_o                          : address errors (combinational)
//   bus_err_o                               : ack timeout pulse
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ramOp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       storeData_i,
  input  logic              flush,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_be_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  output logic [31:0]       load_data_o,
  output logic              load_valid_o,
  output logic              stall_req_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e           r_state;
  logic [3:0]       r_op;
  logic [1:0]       r_addr_lo;
  logic [CNT_W-1:0] r_cnt;

  logic             w_valid;
  logic             w_misal;
  logic             w_issue;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_timeout;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_load_fmt;

  mem_lane_format u_lane (
    .i_st_op      (ramOp_i),
    .i_st_addr_lo (addr_i[1:0]),
    .i_st_data    (storeData_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .i_ld_op      (r_op),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (bus_rdata_i),
    .o_load_data  (w_load_fmt)
  );

  assign w_valid = (ramOp_i != MEM_NOP);
  assign w_misal = is_misaligned(ramOp_i, addr_i[1:0]);
  assign w_issue = (r_state == ST_IDLE) && w_valid && !w_misal && !flush;

  assign adel_o = (r_state == ST_IDLE) && w_valid && w_misal && is_load(ramOp_i);
  assign ades_o = (r_state == ST_IDLE) && w_valid && w_misal && is_store(ramOp_i);

  // Saturating wait counter; timeout fires on the cycle it would reach TIMEOUT.
  assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == CNT_W'(TIMEOUT));

  // DONE releases the stall for one cycle; DRAIN only holds for a new op.
  always_comb begin
    stall_req_o = 1'b0;
    case (r_state)
      ST_IDLE:  stall_req_o = w_issue;
      ST_BUSY:  stall_req_o = 1'b1;
      ST_DONE:  stall_req_o = 1'b0;
      ST_DRAIN: stall_req_o = w_valid;
      default:  stall_req_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_op         <= MEM_NOP;
      r_addr_lo    <= '0;
      r_cnt        <= '0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_be_o     <= '0;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      load_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store(ramOp_i);
            bus_be_o    <= w_be;
            bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
            bus_wdata_o <= w_wdata;
            r_op        <= ramOp_i;
            r_addr_lo   <= addr_i[1:0];
            r_cnt       <= '0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_cnt <= w_cnt_next;
          // Ack has priority over both timeout and a concurrent flush.
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (is_load(r_op)) begin
              load_data_o  <= w_load_fmt;
              load_valid_o <= 1'b1;
            end
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            r_state   <= ST_DONE;
          end else if (flush) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_DRAIN: begin
          r_cnt <= w_cnt_next;
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (w_timeout) begin
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register's memory fields (ramOp, address, storeData).
- Turns each memory op into one req/ack bus transaction, with byte enables and store-lane replication.
- Formats load data (sign/zero extension) and raises a stall request while a transaction is outstanding, so EX/MEM and earlier stages hold.
- Detects misaligned accesses and reports them as AdEL/AdES without touching the bus.

Parameters:
- ADDR_W, 32, bus address width.
- TIMEOUT, 255, max cycles waiting for ack before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ramOp_i  in  4  memory op from EX/MEM; encoding in shared package.
- addr_i  in  ADDR_W  effective address.
- storeData_i  in  32  store source register value.
- flush  in  1  pipeline flush; current op is squashed.
- bus_ack_i  in  1  responder completion strobe.
- bus_rdata_i  in  32  read data, valid with bus_ack_i.
- bus_req_o  out  1  request; held high until ack.
- bus_we_o  out  1  1 = write.
- bus_be_o  out  4  byte enables, bit n = byte lane n.
- bus_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- bus_wdata_o  out  32  lane-replicated store data.
- load_data_o  out  32  formatted load result.
- load_valid_o  out  1  one-cycle pulse, load_data_o valid.
- stall_req_o  out  1  hold request to the pipeline stall controller.
- adel_o  out  1  load address error, combinational.
- ades_o  out  1  store address error, combinational.
- bus_err_o  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset values: state IDLE; all registered outputs 0. This covers bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, load_data_o, load_valid_o, bus_err_o and the timeout counter. Reset mid-transaction abandons it immediately; no ack is awaited.
- Op classes: valid = ramOp_i != MEM_NOP. Loads are LB, LBU, LH, LHU, LW; stores are SB, SH, SW.
- Misalignment:
  - Halfword ops with addr[0]=1, or word ops with addr[1:0]!=0, are misaligned.
  - Misaligned load sets adel_o=1; misaligned store sets ades_o=1, both combinationally in IDLE.
  - A misaligned op issues no bus request and does not assert stall_req_o.
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE:
  - Aligned valid op with flush=0: stall_req_o=1 combinationally this cycle.
  - Next edge registers bus_req_o=1, we/be/addr/wdata, and moves to BUSY.
  - Otherwise the state stays IDLE.
- BUSY:
  - stall_req_o=1 and bus_req_o held.
  - On bus_ack_i: bus_req_o drops next edge. For a load, load_data_o is captured and load_valid_o pulses. Next state is DONE.
  - If the counter reaches TIMEOUT without ack: bus_err_o pulses, bus_req_o drops, next state is DONE.
  - flush=1 without ack: next state is DRAIN.
- DONE: stall_req_o=0 for exactly one cycle so EX/MEM advances; no new issue in this cycle, because the same op is still presented. Then IDLE.
- DRAIN:
  - bus_req_o stays high until ack or timeout; the data is discarded and load_valid_o does not pulse. Then IDLE.
  - stall_req_o = 1 if a new valid op is presented, else 0.
- Latency: ack in the cycle after issue gives 3 cycles from op presentation to pipeline release (IDLE, BUSY, DONE).
- Byte lanes (little-endian):
  - SB: be = 1 << addr[1:0]; wdata = {4{storeData_i[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{storeData_i[15:0]}}.
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111, we = 0.
- Load formatting: select the lane by the registered addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Simultaneous ack and flush in BUSY: ack wins, the transaction completes normally, and the next state is DONE.
- Timeout counter: cleared on issue, increments each BUSY/DRAIN cycle, saturates.

Decomposition:
- Shared package holds:
  - MEM_NOP, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW (4-bit codes, MEM_NOP=4'h0).
  - State encodings.
  - is_load/is_store helpers.
- One sub-module: mem_lane_format. It is combinational and does both store replication/byte enables and load extraction/extension. The FSM, counter and registers stay in mem_access_unit.

Test Plan:
- LB addr=0x1003, ack next cycle, rdata=0x80AABBCC -> bus_be=4'b1111, bus_addr=0x1000, load_data_o=0xFFFFFF80, load_valid_o one pulse, stall_req_o high 2 cycles then low 1.
- SH addr=0x2002, storeData=0x1234ABCD -> bus_we=1, bus_be=4'b1100, bus_wdata=0xABCDABCD, no load_valid_o.
- LW addr=0x3001 -> adel_o=1 same cycle, bus_req_o never rises, stall_req_o=0; SW addr=0x3002 -> ades_o=1.
- LHU addr=0x4000, ack withheld 5 cycles -> bus_req_o and stall_req_o held 5 cycles; rdata=0x0000F00D -> load_data_o=0x0000F00D.
- LW issued, flush in 2nd BUSY cycle, ack 3 cycles later -> DRAIN, load_valid_o never pulses, bus_req_o falls after ack.
- TIMEOUT=4, no ack -> bus_err_o pulses after 4 BUSY cycles, bus_req_o drops; rst asserted mid-BUSY in another run -> all outputs 0 next edge.
